// File: rtl/vslc_pkg.sv
// Shared definitions for the VSLC program sequencer and executor.
//   seq_state_t : sequencer state encoding
//   instr_t     : one ladder instruction byte
//   OPC_CLASS_* : opcode-class field (instr[7:6]), shared with the executor
//                 for assertions and debug decode
package vslc_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_SNAP,
    SEQ_ISSUE,
    SEQ_GAP
  } seq_state_t;

  typedef logic [7:0] instr_t;

  localparam int unsigned OPC_CLASS_MSB = 7;
  localparam int unsigned OPC_CLASS_LSB = 6;

  localparam logic [1:0] OPC_CLASS_LOGIC = 2'b00;
  localparam logic [1:0] OPC_CLASS_EDGE  = 2'b01;
  localparam logic [1:0] OPC_CLASS_TIMER = 2'b10;
  localparam logic [1:0] OPC_CLASS_SYS   = 2'b11;

  function automatic logic [1:0] opc_class(input instr_t i);
    return i[OPC_CLASS_MSB:OPC_CLASS_LSB];
  endfunction

endpackage

// File: rtl/vslc_prog_mem.sv
// Program store for the VSLC sequencer: DEPTH x 8 register file.
// Ports:
//   clk      - write clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - byte to store
//   rd_addr  - read address
//   rd_data  - combinational read data (so the caller can register it
//              in the same cycle it presents the address)
// Contents are not reset.
module vslc_prog_mem
  import vslc_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  instr_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output instr_t        rd_data
);

  instr_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vslc_program_sequencer.sv
// VSLC program sequencer: loads a ladder program through a byte stream,
// then replays it as a repeating scan (SNAP -> ISSUE x prog_len -> GAP).
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   load_start/valid/data/done - program load stream
//   run_en                - level, allow scanning
//   ui_pins               - raw (already synchronised) input pins
//   instr, instr_ready    - instruction to executor and its valid
//   ui_in, ui_in_prev     - this / previous scan's input snapshot
//   running               - high while in ISSUE or GAP
//   prog_len              - latched program length (0..DEPTH)
//   overflow              - sticky, load bytes were dropped
// Optional build macro VSLC_SEQ_SINGLE_STEP_EN adds inputs step (pulse) and
// step_mode (level): with step_mode=1, ISSUE emits one instruction per step.
module vslc_program_sequencer
  import vslc_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned PC_W    = $clog2(DEPTH),
  parameter int unsigned END_GAP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  input  logic          load_done,
  input  logic          run_en,
  input  logic [7:0]    ui_pins,
`ifdef VSLC_SEQ_SINGLE_STEP_EN
  input  logic          step,
  input  logic          step_mode,
`endif
  output logic [7:0]    instr,
  output logic          instr_ready,
  output logic [7:0]    ui_in,
  output logic [7:0]    ui_in_prev,
  output logic          running,
  output logic [PC_W:0] prog_len,
  output logic          overflow
);

  localparam logic [PC_W:0]   LEN_ONE  = 1;
  localparam logic [PC_W-1:0] PC_ONE   = 1;
  localparam logic [PC_W:0]   LEN_FULL = DEPTH[PC_W:0];
  localparam logic [3:0]      GAP_LAST = 4'(END_GAP - 1);

  seq_state_t      state, state_nxt;
  logic [PC_W-1:0] pc;
  // One bit wider than the address so a full memory (DEPTH) is representable.
  logic [PC_W:0]   wr_ptr;
  logic [3:0]      gap_cnt;
  logic            load_pend;
  instr_t          rd_data;

  logic load_clr, wr_en, drop, len_latch, snap, issue, step_ok;
  logic wr_full, pc_last;

`ifdef VSLC_SEQ_SINGLE_STEP_EN
  assign step_ok = !step_mode || step;
`else
  assign step_ok = 1'b1;
`endif

  assign wr_full = (wr_ptr >= LEN_FULL);
  assign pc_last = ({1'b0, pc} == (prog_len - LEN_ONE));

  vslc_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (PC_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[PC_W-1:0]),
    .wr_data (load_data),
    .rd_addr (pc),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEQ_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_clr  = 1'b0;
    wr_en     = 1'b0;
    drop      = 1'b0;
    len_latch = 1'b0;
    snap      = 1'b0;
    issue     = 1'b0;
    unique case (state)
      SEQ_IDLE: begin
        if (load_start) begin
          state_nxt = SEQ_LOAD;
          load_clr  = 1'b1;
        end else if (run_en && prog_len != '0) begin
          state_nxt = SEQ_SNAP;
        end
      end
      SEQ_LOAD: begin
        if (load_start) begin
          load_clr = 1'b1;
        end else begin
          wr_en = load_valid && !wr_full;
          drop  = load_valid && wr_full;
          if (load_done) begin
            len_latch = 1'b1;
            state_nxt = SEQ_IDLE;
          end
        end
      end
      SEQ_SNAP: begin
        snap      = 1'b1;
        state_nxt = SEQ_ISSUE;
      end
      SEQ_ISSUE: begin
        if (step_ok) begin
          issue = 1'b1;
          if (pc_last) state_nxt = SEQ_GAP;
        end
      end
      SEQ_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          // A reload requested mid-scan wins over the next scan.
          if (load_pend || load_start) begin
            state_nxt = SEQ_LOAD;
            load_clr  = 1'b1;
          end else if (run_en) begin
            state_nxt = SEQ_SNAP;
          end else begin
            state_nxt = SEQ_IDLE;
          end
        end
      end
      default: state_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_ready <= 1'b0;
      ui_in       <= '0;
      ui_in_prev  <= '0;
      running     <= 1'b0;
      prog_len    <= '0;
      overflow    <= 1'b0;
      pc          <= '0;
      wr_ptr      <= '0;
      gap_cnt     <= '0;
      load_pend   <= 1'b0;
    end else begin
      instr_ready <= issue;
      running     <= (state_nxt == SEQ_ISSUE) || (state_nxt == SEQ_GAP);

      if (snap) begin
        ui_in_prev <= ui_in;
        ui_in      <= ui_pins;
        pc         <= '0;
      end else if (issue) begin
        instr <= rd_data;
        pc    <= pc + PC_ONE;
      end

      if (state == SEQ_GAP && state_nxt == SEQ_GAP) gap_cnt <= gap_cnt + 4'd1;
      else                                          gap_cnt <= '0;

      if (load_clr) begin
        wr_ptr   <= '0;
        overflow <= 1'b0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + LEN_ONE;
      end else if (drop) begin
        overflow <= 1'b1;
      end

      // A byte arriving with load_done is counted in the latched length.
      if (len_latch) prog_len <= wr_en ? wr_ptr + LEN_ONE : wr_ptr;

      if (load_clr)
        load_pend <= 1'b0;
      else if (load_start && (state == SEQ_SNAP || state == SEQ_ISSUE || state == SEQ_GAP))
        load_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vslc_program_sequencer.sv
// Self-checking bench for vslc_program_sequencer (DEPTH=32, END_GAP=2).
// Build with VSLC_SEQ_SINGLE_STEP_EN defined to include the single-step test.
module tb_vslc_program_sequencer;

  localparam int DEPTH   = 32;
  localparam int END_GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_start = 1'b0, load_valid = 1'b0, load_done = 1'b0;
  logic [7:0] load_data = '0;
  logic       run_en = 1'b0;
  logic [7:0] ui_pins = '0;
`ifdef VSLC_SEQ_SINGLE_STEP_EN
  logic       step = 1'b0, step_mode = 1'b0;
`endif
  logic [7:0] instr, ui_in, ui_in_prev;
  logic       instr_ready, running, overflow;
  logic [5:0] prog_len;

  vslc_program_sequencer #(
    .DEPTH   (DEPTH),
    .END_GAP (END_GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_done   (load_done),
    .run_en      (run_en),
    .ui_pins     (ui_pins),
`ifdef VSLC_SEQ_SINGLE_STEP_EN
    .step        (step),
    .step_mode   (step_mode),
`endif
    .instr       (instr),
    .instr_ready (instr_ready),
    .ui_in       (ui_in),
    .ui_in_prev  (ui_in_prev),
    .running     (running),
    .prog_len    (prog_len),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] ui;
    logic [7:0] prev;
    int         gap;   // expected low cycles before this pulse, -1 = don't care
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_errors = 0;
  int         low_run  = 0;
  logic [7:0] stim   [40];
  logic [7:0] prog_m [DEPTH];
  int         model_len = 0;
  logic [7:0] last_ui   = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every instr_ready pulse must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_ready", 32'(instr_ready), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("instr", 32'(instr), 32'(mon_e.instr));
          check_eq("ui_in", 32'(ui_in), 32'(mon_e.ui));
          check_eq("ui_in_prev", 32'(ui_in_prev), 32'(mon_e.prev));
          if (mon_e.gap >= 0) check_eq("gap_len", 32'(low_run), 32'(mon_e.gap));
        end
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  task automatic push_scan(input int first_gap, input logic [7:0] pins);
    exp_t e;
    for (int i = 0; i < model_len; i++) begin
      e.instr = prog_m[i];
      e.ui    = pins;
      e.prev  = last_ui;
      e.gap   = (i == 0) ? first_gap : 0;
      sb_q.push_back(e);
    end
    last_ui = pins;
  endtask

  task automatic load_bytes(input int n, input bit merge);
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = stim[i];
      load_done  = merge && (i == n - 1);
      if (i < DEPTH) prog_m[i] = stim[i];
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_done  = 1'b0;
    if (!merge || n == 0) begin
      load_done = 1'b1;
      @(negedge clk);
      load_done = 1'b0;
    end
    model_len = (n > DEPTH) ? DEPTH : n;
    @(negedge clk);
  endtask

  task automatic wait_size(input string tag, input int target);
    int cyc = 0;
    while (sb_q.size() > target && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) check_eq({tag, "_timeout"}, 32'(sb_q.size()), 32'(target));
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while ((running || sb_q.size() != 0) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_running"}, 32'(running), 32'd0);
    check_eq({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic run_one(input string tag);
    push_scan(-1, ui_pins);
    @(negedge clk); run_en = 1'b1;
    @(negedge clk); run_en = 1'b0;
    wait_idle(tag);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_instr", 32'(instr), 32'd0);
    check_eq("rst_ready", 32'(instr_ready), 32'd0);
    check_eq("rst_ui_in", 32'(ui_in), 32'd0);
    check_eq("rst_ui_prev", 32'(ui_in_prev), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_prog_len", 32'(prog_len), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);

    // Empty program never scans
    load_bytes(0, 1'b0);
    check_eq("empty_len", 32'(prog_len), 32'd0);
    run_en = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("empty_running", 32'(running), 32'd0);
    check_eq("empty_ready", 32'(instr_ready), 32'd0);
    run_en = 1'b0;

    // Load and run two scans; inputs change mid-scan 1
    stim[0] = 8'h00; stim[1] = 8'h90; stim[2] = 8'h18;
    load_bytes(3, 1'b0);
    check_eq("ld3_len", 32'(prog_len), 32'd3);
    check_eq("ld3_ovf", 32'(overflow), 32'd0);
    ui_pins = 8'h01;
    push_scan(-1, 8'h01);
    push_scan(END_GAP + 1, 8'h03);
    @(negedge clk); run_en = 1'b1;
    wait_size("snap_s1", 5);
    ui_pins = 8'h03;
    wait_size("snap_s2", 2);
    run_en = 1'b0;
    wait_idle("snap");

    // Halt: run_en drops at the 2nd instruction, scan still completes
    for (int i = 0; i < 5; i++) stim[i] = 8'(8'h41 + i * 8'h11);
    load_bytes(5, 1'b0);
    check_eq("ld5_len", 32'(prog_len), 32'd5);
    ui_pins = 8'h80;
    push_scan(-1, 8'h80);
    @(negedge clk); run_en = 1'b1;
    wait_size("halt_mid", 3);
    run_en = 1'b0;
    check_eq("halt_running_mid", 32'(running), 32'd1);
    wait_idle("halt");
    repeat (6) @(negedge clk);
    check_eq("halt_stays_idle", 32'(running), 32'd0);
    check_eq("halt_ready", 32'(instr_ready), 32'd0);

    // Overflow: 35 bytes into a 32-byte store
    for (int i = 0; i < 35; i++) stim[i] = 8'(i * 37 + 5);
    load_bytes(35, 1'b0);
    check_eq("ovf_len", 32'(prog_len), 32'd32);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    ui_pins = 8'h5C;
    run_one("ovf_scan");

    // Reload requested mid-scan is deferred until the scan ends
    push_scan(-1, ui_pins);
    @(negedge clk); run_en = 1'b1;
    wait_size("pend_mid", 30);
    load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    wait_idle("pend");
    run_en = 1'b0;
    stim[0] = 8'hA5; stim[1] = 8'h5A;
    load_bytes(2, 1'b1);
    check_eq("merge_len", 32'(prog_len), 32'd2);
    check_eq("merge_ovf_clr", 32'(overflow), 32'd0);
    run_one("merge_scan");

    // Asynchronous reset mid-ISSUE
    for (int i = 0; i < 20; i++) stim[i] = 8'(8'hC0 ^ i);
    load_bytes(20, 1'b0);
    push_scan(-1, ui_pins);
    @(negedge clk); run_en = 1'b1;
    wait_size("arst_mid", 15);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_ready", 32'(instr_ready), 32'd0);
    check_eq("arst_running", 32'(running), 32'd0);
    check_eq("arst_len", 32'(prog_len), 32'd0);
    sb_q.delete();
    last_ui = '0;
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("arst_no_scan", 32'(running), 32'd0);
    run_en = 1'b0;

`ifdef VSLC_SEQ_SINGLE_STEP_EN
    // Single step: one instruction per step pulse
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
    load_bytes(3, 1'b0);
    step = 1'b1; @(negedge clk); step = 1'b0;
    step_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{instr: prog_m[i], ui: ui_pins, prev: last_ui, gap: -1});
    end
    last_ui = ui_pins;
    @(negedge clk); run_en = 1'b1;
    @(negedge clk); run_en = 1'b0;
    begin
      int cyc = 0;
      while (!running && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check_eq("step_running", 32'(running), 32'd1);
    end
    repeat (4) @(negedge clk);
    check_eq("step_hold_ready", 32'(instr_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; @(negedge clk); step = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("step_left", 32'(sb_q.size()), 32'(2 - i));
    end
    wait_idle("step");
    step_mode = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check_eq("final_queue", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vslc_program_sequencer.md
Name: vslc_program_sequencer

Overview:
- Instruction source and scan-cycle controller for the VSLC executor. It drives the executor's `instr` / `instr_ready` / `ui_in` / `ui_in_prev` inputs.
- Holds the ladder program in a small byte-wide register-file memory, loaded through a byte stream, then replays it as a repeating PLC scan.
- Snapshots the inputs once per scan so that edge instructions see a consistent current/previous pair.

Parameters:
- DEPTH, 32: program memory size in instruction bytes; power of two, 2..256.
- PC_W, $clog2(DEPTH): width of the program counter and write pointer.
- END_GAP, 1: idle cycles between scans (`instr_ready` low); range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  pulse: enter LOAD, clear write pointer.
- load_valid  in  1  load_data holds a program byte this cycle.
- load_data  in  8  program byte.
- load_done  in  1  pulse: close LOAD, latch program length.
- run_en  in  1  level: allow scanning.
- ui_pins  in  8  raw input pins; already synchronised upstream.
- instr  out  8  current instruction; drives executor instr.
- instr_ready  out  1  instr valid this cycle; executor consumes on the following negedge.
- ui_in  out  8  this scan's input snapshot.
- ui_in_prev  out  8  previous scan's snapshot.
- running  out  1  high in ISSUE/GAP.
- prog_len  out  PC_W+1  latched program length, 0..DEPTH.
- overflow  out  1  sticky; bytes were dropped in LOAD.

Behaviour:
- Reset values: state=IDLE; instr=0, instr_ready=0, ui_in=0, ui_in_prev=0, running=0, prog_len=0, overflow=0; pc=0, wr_ptr=0.
- Memory contents are not reset.
- Outputs are registered and change only on posedge, so they are stable at the executor's negedge sample.
- States: IDLE, LOAD, SNAP, ISSUE, GAP.
- IDLE:
  - load_start goes to LOAD.
  - Otherwise, run_en=1 and prog_len!=0 goes to SNAP.
- LOAD:
  - On load_start entry: wr_ptr=0, overflow=0.
  - Each cycle with load_valid=1: if wr_ptr<DEPTH, write mem[wr_ptr]=load_data and increment wr_ptr; else drop the byte and set overflow=1.
  - load_done: prog_len=wr_ptr, go to IDLE.
  - load_valid and load_done in the same cycle: the byte is written first and is included in prog_len.
  - load_start during LOAD restarts the load: wr_ptr=0, overflow=0.
  - run_en is ignored in LOAD.
- SNAP (1 cycle): ui_in_prev<=ui_in, ui_in<=ui_pins, pc=0, go to ISSUE.
  - The first scan after reset therefore sees prev=0.
- ISSUE:
  - Each cycle: instr=mem[pc], instr_ready=1, pc++.
  - pc==prog_len-1 goes to GAP.
  - Exactly prog_len consecutive instr_ready pulses per scan, in program order, with no bubbles.
- GAP:
  - instr_ready=0 for END_GAP cycles; the executor's timer-output refresh runs here.
  - Then: if run_en=1, go to SNAP; else go to IDLE.
- Halting: run_en dropping mid-scan does not abort the scan. The scan completes and the sequencer then stops.
- Reloading: load_start during ISSUE/GAP is held pending and taken at the end of GAP, in priority over SNAP. The program is never modified mid-scan.
- Asynchronous reset mid-scan: outputs return to reset values immediately; the next scan starts only after run_en with prog_len!=0.
- ui_in is constant for a whole scan.

Optional Feature:
- Macro: VSLC_SEQ_SINGLE_STEP_EN
- With the macro: adds input `step` (1-bit pulse) and input `step_mode` (level).
  - When step_mode=1, ISSUE emits one instruction per step pulse.
  - instr_ready is 1 for exactly that cycle; pc holds between pulses.
  - SNAP and GAP are unaffected.
  - step pulses outside ISSUE are ignored.
- Without the macro: ports absent; free-running issue as above.

Decomposition:
- Shared package vslc_pkg:
  - Sequencer state enum.
  - Instruction byte typedef.
  - Opcode-class field constants (bits [7:6]), shared with the executor for assertions and debug.
- Sub-module vslc_prog_mem: DEPTH x 8, one synchronous write port, one asynchronous read port.
  - The read is combinational so instr is registered in the same cycle as pc.

Test Plan:
- Load and run:
  - Stimulus: load 3 bytes 0x00, 0x90, 0x18; load_done; run_en=1.
  - Response: prog_len=3; per scan instr_ready high 3 consecutive cycles carrying 0x00, 0x90, 0x18, then END_GAP low cycles, repeating.
- Snapshot:
  - Stimulus: ui_pins=0x01 during scan 1, changed to 0x03 mid-scan 1.
  - Response: ui_in=0x01 throughout scan 1; scan 2 shows ui_in=0x03, ui_in_prev=0x01.
- Overflow:
  - Stimulus: DEPTH=32; stream 35 bytes; load_done.
  - Response: prog_len=32, overflow=1; the first 32 bytes are replayed.
- Halt:
  - Stimulus: drop run_en at the 2nd instruction of a 5-instruction program.
  - Response: all 5 instructions issued, GAP, then IDLE with running=0.
- Empty program and reset:
  - Stimulus: load_start then load_done with no bytes, then run_en=1.
  - Response: stays IDLE with instr_ready=0.
  - Stimulus: assert rst_n low mid-ISSUE.
  - Response: instr_ready=0 immediately.
- Single step (macro on):
  - Stimulus: step_mode=1; three step pulses spaced 5 cycles apart.
  - Response: exactly three 1-cycle instr_ready pulses, pc=3 after the third.
